filter_pair_sched: RTL and testbench
====================================

// Module: filter_pair_sched
// PURPOSE
//  Sequencer for the 6x6 activation/weight filter matrix. On start it snapshots the
//  matrix result vectors and builds an eligibility mask of surviving (i,j) pairs.
//  It then streams the surviving pairs one per handshake, lowest flat index first,
//  to the downstream scatter-gather PIM issue stage, then pulses done.
//  Sits between the filter matrix outputs and the PIM compute-issue logic.
// PARAMETERS
//  ROWS   6  activation divisions (matrix rows i)
//  COLS   6  weight divisions (matrix columns j)
//  OUT_W  6  bits per filterOut entry
//  WGT_W  5  bits per filterWeight entry
// PORTS
//  clk           in   1           system clock, all logic on posedge
//  reset         in   1           synchronous, active-low reset
//  start         in   1           begin a pass; sampled only in IDLE
//  n             in   4           active rows; values >6 clamp to 6, 0 = none
//  m             in   4           active cols; values >6 clamp to 6, 0 = none
//  filterBit     in   36          per-pair keep bit, flat k = i*6+j
//  drop          in   36          per-pair drop flag, flat k
//  filterOut     in   216         per-pair code, bits [6k+5:6k]
//  filterWeight  in   180         per-pair weight, bits [5k+4:5k]
//  out_valid     out  1           pair presented
//  out_ready     in   1           downstream accepts pair
//  out_i         out  3           row index of presented pair
//  out_j         out  3           column index of presented pair
//  out_code      out  6           filterOut entry of presented pair
//  out_weight    out  5           filterWeight entry of presented pair
//  out_last      out  1           presented pair is final of pass
//  busy          out  1           high in LOAD/RUN
//  done          out  1           one-cycle pulse at end of pass
//  pair_count    out  6           pairs transferred this pass (0..36)
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state IDLE.
//    All outputs 0; mask, snapshot and pair_count cleared.
//    Applies mid-pass: current pass is abandoned, no done pulse.
//  - Eligibility: elig[k] = filterBit[k] & ~drop[k] & (i<min(n,6)) & (j<min(m,6)).
//  - States:
//    - IDLE: start==1 -> LOAD. Snapshot filterOut/filterWeight, capture elig into mask,
//      latch clamped n/m, and clear pair_count, all on the same edge.
//    - LOAD: mask==0 -> DONE. Otherwise register the lowest set k into the output
//      regs and set out_valid -> RUN. First out_valid is visible 2 edges after start.
//    - RUN: when out_valid&out_ready, clear bit k, increment pair_count, and load the
//      next lowest set bit in the same edge; back-to-back throughput is 1 pair/cycle.
//      - If the cleared bit was the last one: out_valid->0, go to DONE.
//      - out_valid&~out_ready: all out_* held stable; out_valid never drops without
//        a handshake.
//    - DONE: done=1 for exactly one cycle -> IDLE; pair_count holds until next start.
//  - out_i = k/6, out_j = k%6. out_last = out_valid & (mask has exactly one set bit).
//  - start outside IDLE is ignored. Inputs changing after the snapshot edge have no
//    effect on the pass.
//  - Empty pass (mask==0, or n==0, or m==0): no out_valid; done pulses 2 cycles after
//    start; pair_count = 0.
//  - busy = (state==LOAD)|(state==RUN); deasserts in the DONE cycle.
// STRUCTURE
//  - Shared package holds: ROWS/COLS/OUT_W/WGT_W constants, state encoding
//    {IDLE,LOAD,RUN,DONE}, and flat-index <-> (i,j) conversion functions.
//  - One sub-module: pair_priority_enc.
//    - 36-bit lowest-set-bit finder; outputs index[5:0], any, and onehot (used for the
//      mask clear).
//    - Purely combinational; instantiated once on the mask-with-current-cleared path.
// TESTING
//  1. n=6, m=6, all filterBit=1, drop=0, out_ready=1 -> 36 transfers k=0..35 on
//     consecutive cycles; out_last on k=35; done next cycle; pair_count=36.
//  2. n=2, m=3, filterBit=all 1 -> pairs (0,0),(0,1),(0,2),(1,0),(1,1),(1,2) only;
//     pair_count=6.
//  3. filterBit=1 only at k=7 and k=30, drop[30]=1, n=m=6 -> single pair (1,1) with
//     out_last=1, and its code/weight taken from bits [47:42]/[39:35].
//  4. filterBit=0 (or n=0) -> no out_valid; done 2 cycles after start; pair_count=0.
//  5. out_ready toggles 1,0,0,1 and inputs are changed during the stall -> presented
//     data stable through the stall; sequence matches the snapshot.
//  6. reset=0 after 3 of 10 transfers -> next cycle all outputs 0 and state IDLE, no
//     done pulse; start mid-RUN is ignored.

Source files
------------

// File: rtl/filter_pair_sched_pkg.sv
// rtl/filter_pair_sched_pkg.sv - shared constants, state encoding and index helpers
package filter_pair_sched_pkg;

  localparam int ROWS  = 6;
  localparam int COLS  = 6;
  localparam int OUT_W = 6;
  localparam int WGT_W = 5;
  localparam int NPAIR = ROWS * COLS;
  localparam int IDX_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Row index of a flat pair index
  function automatic logic [2:0] flat_to_i(input logic [IDX_W-1:0] k);
    logic [IDX_W-1:0] q;
    q = k / IDX_W'(COLS);
    return q[2:0];
  endfunction

  // Column index of a flat pair index
  function automatic logic [2:0] flat_to_j(input logic [IDX_W-1:0] k);
    logic [IDX_W-1:0] r;
    r = k % IDX_W'(COLS);
    return r[2:0];
  endfunction

  // Flat pair index of (i,j)
  function automatic logic [IDX_W-1:0] ij_to_flat(input logic [2:0] i, input logic [2:0] j);
    return IDX_W'(i) * IDX_W'(COLS) + IDX_W'(j);
  endfunction

endpackage

// File: rtl/filter_pair_sched_prio_enc.sv
// rtl/filter_pair_sched_prio_enc.sv - lowest-set-bit finder over the pair mask
module pair_priority_enc
  import filter_pair_sched_pkg::*;
(
  input  logic [NPAIR-1:0] vec_i,
  output logic [IDX_W-1:0] index_o,
  output logic             any_o,
  output logic [NPAIR-1:0] onehot_o
);

  // Scan high to low so the lowest set bit is the last one written
  always_comb begin
    index_o = '0;
    for (int k = NPAIR - 1; k >= 0; k--) begin
      if (vec_i[k]) begin
        index_o = IDX_W'(k);
      end
    end
    any_o    = |vec_i;
    onehot_o = vec_i & (~vec_i + NPAIR'(1));
  end

endmodule

// File: rtl/filter_pair_sched.sv
// rtl/filter_pair_sched.sv - streams surviving filter-matrix pairs lowest index first
module filter_pair_sched
  import filter_pair_sched_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [3:0]             n,
  input  logic [3:0]             m,
  input  logic [NPAIR-1:0]       filterBit,
  input  logic [NPAIR-1:0]       drop,
  input  logic [NPAIR*OUT_W-1:0] filterOut,
  input  logic [NPAIR*WGT_W-1:0] filterWeight,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2:0]             out_i,
  output logic [2:0]             out_j,
  output logic [OUT_W-1:0]       out_code,
  output logic [WGT_W-1:0]       out_weight,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done,
  output logic [5:0]             pair_count
);

  state_e                   state_q, state_d;
  // mask_q holds pairs not yet presented; the presented pair is already cleared
  logic [NPAIR-1:0]         mask_q, mask_d;
  logic [NPAIR*OUT_W-1:0]   code_q, code_d;
  logic [NPAIR*WGT_W-1:0]   wgt_q, wgt_d;
  logic [5:0]               cnt_q, cnt_d;
  logic                     valid_q, valid_d;
  logic [IDX_W-1:0]         k_q, k_d;

  logic [2:0]               n_clamp, m_clamp;
  logic [NPAIR-1:0]         elig;
  logic [IDX_W-1:0]         enc_index;
  logic                     enc_any;
  logic [NPAIR-1:0]         enc_onehot;

  pair_priority_enc u_enc (
    .vec_i    (mask_q),
    .index_o  (enc_index),
    .any_o    (enc_any),
    .onehot_o (enc_onehot)
  );

  // Eligibility of every pair from the live inputs, captured only on the start edge
  always_comb begin
    n_clamp = (n > 4'd6) ? 3'd6 : n[2:0];
    m_clamp = (m > 4'd6) ? 3'd6 : m[2:0];
    elig    = '0;
    for (int i = 0; i < ROWS; i++) begin
      for (int j = 0; j < COLS; j++) begin
        elig[ij_to_flat(3'(i), 3'(j))] = filterBit[ij_to_flat(3'(i), 3'(j))]
                                       & ~drop[ij_to_flat(3'(i), 3'(j))]
                                       & (3'(i) < n_clamp) & (3'(j) < m_clamp);
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: mask, snapshot, presented pair and transfer count
  always_ff @(posedge clk) begin
    if (!reset) begin
      mask_q  <= '0;
      code_q  <= '0;
      wgt_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      k_q     <= '0;
    end else begin
      mask_q  <= mask_d;
      code_q  <= code_d;
      wgt_q   <= wgt_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      k_q     <= k_d;
    end
  end

  // Next state and datapath updates; a handshake advances to the next pair in the same edge
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    code_d  = code_q;
    wgt_d   = wgt_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    k_d     = k_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          mask_d  = elig;
          code_d  = filterOut;
          wgt_d   = filterWeight;
          cnt_d   = '0;
          valid_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (!enc_any) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
          valid_d = 1'b1;
          k_d     = enc_index;
          mask_d  = mask_q & ~enc_onehot;
        end
      end
      ST_RUN: begin
        if (valid_q && out_ready) begin
          cnt_d = cnt_q + 6'd1;
          if (enc_any) begin
            k_d    = enc_index;
            mask_d = mask_q & ~enc_onehot;
          end else begin
            valid_d = 1'b0;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from the registered state and presented pair index
  always_comb begin
    out_valid  = valid_q;
    out_i      = flat_to_i(k_q);
    out_j      = flat_to_j(k_q);
    out_code   = code_q[int'(k_q) * OUT_W +: OUT_W];
    out_weight = wgt_q[int'(k_q) * WGT_W +: WGT_W];
    out_last   = valid_q & (mask_q == '0);
    busy       = (state_q == ST_LOAD) || (state_q == ST_RUN);
    done       = (state_q == ST_DONE);
    pair_count = cnt_q;
  end

endmodule

// File: tb/tb_filter_pair_sched.sv
// tb/tb_filter_pair_sched.sv - scoreboard bench for filter_pair_sched
module tb_filter_pair_sched;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   n, m;
  logic [35:0]  filterBit, drop;
  logic [215:0] filterOut;
  logic [179:0] filterWeight;
  logic         out_valid, out_ready, out_last, busy, done;
  logic [2:0]   out_i, out_j;
  logic [5:0]   out_code, pair_count;
  logic [4:0]   out_weight;

  typedef struct packed {
    logic [2:0] i;
    logic [2:0] j;
    logic [5:0] code;
    logic [4:0] wt;
    logic       last;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt;
  int   done_seen = 0;
  logic stall_prev = 1'b0;
  logic [17:0] prev_obs;

  filter_pair_sched dut (
    .clk(clk), .reset(reset), .start(start), .n(n), .m(m),
    .filterBit(filterBit), .drop(drop), .filterOut(filterOut), .filterWeight(filterWeight),
    .out_valid(out_valid), .out_ready(out_ready), .out_i(out_i), .out_j(out_j),
    .out_code(out_code), .out_weight(out_weight), .out_last(out_last),
    .busy(busy), .done(done), .pair_count(pair_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: compute surviving pairs from the current inputs, in flat order
  task automatic push_expected();
    int nc, mc, total, idx;
    exp_t e;
    nc = (n > 6) ? 6 : int'(n);
    mc = (m > 6) ? 6 : int'(m);
    total = 0;
    for (int k = 0; k < 36; k++)
      if (filterBit[k] && !drop[k] && (k / 6) < nc && (k % 6) < mc) total++;
    idx = 0;
    for (int k = 0; k < 36; k++) begin
      if (filterBit[k] && !drop[k] && (k / 6) < nc && (k % 6) < mc) begin
        e.i    = 3'(k / 6);
        e.j    = 3'(k % 6);
        e.code = filterOut[k*6 +: 6];
        e.wt   = filterWeight[k*5 +: 5];
        e.last = (idx == total - 1);
        sb.push_back(e);
        idx++;
      end
    end
    exp_cnt = total;
  endtask

  task automatic rand_data();
    for (int k = 0; k < 36; k++) begin
      filterOut[k*6 +: 6]    = 6'($urandom);
      filterWeight[k*5 +: 5] = 5'($urandom);
    end
  endtask

  // mode 0: ready held high; mode 1: ready pattern 1,0,0,1 with inputs scrambled every cycle
  task automatic run_pass(input int mode);
    int lat;
    logic got;
    push_expected();
    start = 1'b1;
    out_ready = 1'b1;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 300) begin
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
      if (mode == 1) begin
        out_ready = (lat % 4 == 0) || (lat % 4 == 3);
        filterBit = {$urandom, $urandom};
        drop = {$urandom, $urandom};
        n = 4'($urandom);
        m = 4'($urandom);
        rand_data();
      end
      if (done) got = 1'b1;
    end
    check("done_seen", int'(got), 1);
    if (mode == 0) check("done_latency", lat, 2 + exp_cnt);
    check("pair_count", int'(pair_count), exp_cnt);
    check("sb_empty", sb.size(), 0);
    check("busy_in_done", int'(busy), 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("done_one_cycle", int'(done), 0);
    check("count_holds", int'(pair_count), exp_cnt);
  endtask

  // Output monitor: scoreboard pops on handshake, stall stability checks
  always @(negedge clk) begin
    if (done) done_seen++;
    if (reset) begin
      if (stall_prev) begin
        check("stall_valid", int'(out_valid), 1);
        check("stall_hold", int'({out_i, out_j, out_code, out_weight, out_last}), int'(prev_obs));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_pair", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_i", int'(out_i), int'(e.i));
          check("out_j", int'(out_j), int'(e.j));
          check("out_code", int'(out_code), int'(e.code));
          check("out_weight", int'(out_weight), int'(e.wt));
          check("out_last", int'(out_last), int'(e.last));
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_obs = {out_i, out_j, out_code, out_weight, out_last};
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    int c, d0;
    reset = 1'b0; start = 1'b0; out_ready = 1'b1;
    n = 4'd0; m = 4'd0; filterBit = '0; drop = '0; filterOut = '0; filterWeight = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_count", int'(pair_count), 0);
    check("rst_code", int'(out_code), 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Full matrix, back-to-back
    n = 4'd6; m = 4'd6; filterBit = '1; drop = '0; rand_data();
    run_pass(0);

    // 2x3 sub-window
    n = 4'd2; m = 4'd3; filterBit = '1; drop = '0; rand_data();
    run_pass(0);

    // Single survivor (1,1); k=30 dropped
    n = 4'd6; m = 4'd6; filterBit = '0; filterBit[7] = 1'b1; filterBit[30] = 1'b1;
    drop = '0; drop[30] = 1'b1; rand_data();
    filterOut[47:42] = 6'h2d; filterWeight[39:35] = 5'h13;
    run_pass(0);

    // Empty passes
    n = 4'd6; m = 4'd6; filterBit = '0; drop = '0;
    run_pass(0);
    n = 4'd0; m = 4'd6; filterBit = '1;
    run_pass(0);
    n = 4'd6; m = 4'd0;
    run_pass(0);

    // Clamping of n/m above 6 with random masks
    n = 4'd9; m = 4'd15; filterBit = {$urandom, $urandom}; drop = {$urandom, $urandom}; rand_data();
    run_pass(0);

    // Stalls with inputs changing under the pass
    n = 4'd5; m = 4'd6; filterBit = {$urandom, $urandom}; filterBit[0] = 1'b1; drop = '0; rand_data();
    run_pass(1);

    // Reset mid-pass after 3 of 10 transfers, start held high during RUN
    n = 4'd2; m = 4'd5; filterBit = '1; drop = '0; rand_data();
    push_expected();
    check("rst_test_count", exp_cnt, 10);
    start = 1'b1; out_ready = 1'b1;
    c = 0;
    while (pair_count != 6'd3 && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    check("reach_3", int'(pair_count), 3);
    check("start_ignored_busy", int'(busy), 1);
    check("start_ignored_valid", int'(out_valid), 1);
    reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_ij", int'({out_i, out_j}), 0);
    check("mid_rst_data", int'({out_code, out_weight, out_last}), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_count", int'(pair_count), 0);
    sb.delete();
    d0 = done_seen;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("no_done_after_rst", done_seen, d0);
    check("idle_after_rst", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
